// File: rtl/refill_pkg.sv
// Shared types and default geometry for the instruction-cache line refill engine.
package refill_pkg;

  // Refill controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } refill_state_e;

  // Default memory word width, byte address width and words per line.
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_BLOCK_SIZE = 8;

  // Byte-offset width inside one line and the full line width in bits.
  localparam int DEF_OFFSET_WIDTH = $clog2(DEF_DATA_WIDTH * DEF_BLOCK_SIZE / 8);
  localparam int DEF_LINE_WIDTH   = DEF_BLOCK_SIZE * DEF_DATA_WIDTH;

  // Number of low address bits that select a byte inside one memory word.
  localparam int DEF_WORD_SHIFT = $clog2(DEF_DATA_WIDTH / 8);

endpackage

// File: rtl/icache_line_refill.sv
// Instruction-cache line refill engine.
// Takes one line address from the L1, reads the line as BLOCK_SIZE word beats
// over an in-order memory read channel, assembles the words into a line buffer
// and presents the whole line with a single-cycle valid pulse.
// Optional feature: define REFILL_PENDING_EN to add a one-entry pending request
// register, so a request arriving while busy is started right after the
// current line completes.
module icache_line_refill
  import refill_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
  localparam int OFFSET_WIDTH = $clog2(DATA_WIDTH * BLOCK_SIZE / 8),
  localparam int LINE_WIDTH   = BLOCK_SIZE * DATA_WIDTH
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic                           FLUSH,
  input  logic [ADDR_WIDTH-OFFSET_WIDTH-1:0] ADDR_FROM_L1,
  input  logic                           ADDR_FROM_L1_VALID,
  output logic [LINE_WIDTH-1:0]          DATA_TO_L1,
  output logic                           DATA_TO_L1_VALID,
  output logic                           BUSY,
  output logic [ADDR_WIDTH-1:0]          MEM_ADDR,
  output logic                           MEM_RD_VALID,
  input  logic                           MEM_RD_READY,
  input  logic [DATA_WIDTH-1:0]          MEM_RDATA,
  input  logic                           MEM_RDATA_VALID
);

  localparam int IDX_WIDTH   = $clog2(BLOCK_SIZE);
  localparam int CNT_WIDTH   = IDX_WIDTH + 1;
  localparam int WORD_SHIFT  = $clog2(DATA_WIDTH / 8);
  localparam int LADDR_WIDTH = ADDR_WIDTH - OFFSET_WIDTH;

  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(BLOCK_SIZE);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

  refill_state_e          state, state_n;
  logic [CNT_WIDTH-1:0]   issue_cnt, issue_n;
  logic [CNT_WIDTH-1:0]   recv_cnt, recv_n;
  logic [CNT_WIDTH-1:0]   outstanding;
  logic [LADDR_WIDTH-1:0] line_addr, addr_n;
  logic [DATA_WIDTH-1:0]  line_buf [BLOCK_SIZE];

  logic                   got_rsp;
  logic                   buf_wr;
  logic                   rd_valid;
  logic                   line_valid;

`ifdef REFILL_PENDING_EN
  logic                   pend_valid, pend_valid_n;
  logic [LADDR_WIDTH-1:0] pend_addr, pend_addr_n;
  logic                   next_req_valid;
  logic [LADDR_WIDTH-1:0] next_req_addr;
`endif

  // Reads issued but not yet answered; the counters wrap together so a plain
  // difference is exact even when both have reached BLOCK_SIZE.
  assign outstanding = issue_cnt - recv_cnt;

  // Next-state, counter and handshake decode for the refill controller.
  always_comb begin
    state_n    = state;
    issue_n    = issue_cnt;
    recv_n     = recv_cnt;
    addr_n     = line_addr;
    buf_wr     = 1'b0;
    rd_valid   = 1'b0;
    line_valid = 1'b0;
    got_rsp    = MEM_RDATA_VALID && (outstanding != CNT_ZERO);

`ifdef REFILL_PENDING_EN
    pend_valid_n = pend_valid;
    pend_addr_n  = pend_addr;
    if (FLUSH) begin
      pend_valid_n = 1'b0;
    end else if (ADDR_FROM_L1_VALID && (state != IDLE)) begin
      pend_valid_n = 1'b1;
      pend_addr_n  = ADDR_FROM_L1;
    end
    next_req_valid = !FLUSH && (ADDR_FROM_L1_VALID || pend_valid);
    next_req_addr  = ADDR_FROM_L1_VALID ? ADDR_FROM_L1 : pend_addr;
`endif

    case (state)
      IDLE: begin
        if (ADDR_FROM_L1_VALID && !FLUSH) begin
          state_n = FETCH;
          addr_n  = ADDR_FROM_L1;
          issue_n = CNT_ZERO;
          recv_n  = CNT_ZERO;
        end
      end

      FETCH: begin
        rd_valid = (issue_cnt < CNT_FULL);
        if (rd_valid && MEM_RD_READY && !FLUSH) begin
          issue_n = issue_cnt + CNT_ONE;
        end
        if (got_rsp) begin
          buf_wr = 1'b1;
          recv_n = recv_cnt + CNT_ONE;
        end
        if (FLUSH) begin
          state_n = (recv_n == issue_cnt) ? IDLE : DRAIN;
        end else if (recv_n == CNT_FULL) begin
          state_n = DONE;
        end
      end

      DONE: begin
        line_valid = !FLUSH;
        state_n    = IDLE;
`ifdef REFILL_PENDING_EN
        if (next_req_valid) begin
          state_n      = FETCH;
          addr_n       = next_req_addr;
          issue_n      = CNT_ZERO;
          recv_n       = CNT_ZERO;
          pend_valid_n = 1'b0;
        end
`endif
      end

      DRAIN: begin
        if (got_rsp) begin
          recv_n = recv_cnt + CNT_ONE;
        end
        if (recv_n == issue_cnt) begin
          state_n = IDLE;
`ifdef REFILL_PENDING_EN
          if (next_req_valid) begin
            state_n      = FETCH;
            addr_n       = next_req_addr;
            issue_n      = CNT_ZERO;
            recv_n       = CNT_ZERO;
            pend_valid_n = 1'b0;
          end
`endif
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Controller state, beat counters and latched line address.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      line_addr <= '0;
    end else begin
      state     <= state_n;
      issue_cnt <= issue_n;
      recv_cnt  <= recv_n;
      line_addr <= addr_n;
    end
  end

  // Line buffer: each returned word lands in the slot matching its arrival order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        line_buf[i] <= '0;
      end
    end else if (buf_wr) begin
      line_buf[recv_cnt[IDX_WIDTH-1:0]] <= MEM_RDATA;
    end
  end

`ifdef REFILL_PENDING_EN
  // One-entry holding register for a request that arrives while busy.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
    end else begin
      pend_valid <= pend_valid_n;
      pend_addr  <= pend_addr_n;
    end
  end
`endif

  // Flatten the word array into the line bus the cache expects.
  always_comb begin
    DATA_TO_L1 = '0;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      DATA_TO_L1[i*DATA_WIDTH +: DATA_WIDTH] = line_buf[i];
    end
  end

  // Memory request address is forced to zero outside FETCH so idle outputs stay quiet.
  always_comb begin
    MEM_ADDR = '0;
    if (state == FETCH) begin
      MEM_ADDR = {line_addr, issue_cnt[IDX_WIDTH-1:0], {WORD_SHIFT{1'b0}}};
    end
  end

  assign MEM_RD_VALID     = rd_valid;
  assign DATA_TO_L1_VALID = line_valid;

`ifdef REFILL_PENDING_EN
  assign BUSY = (state != IDLE) || pend_valid;
`else
  assign BUSY = (state != IDLE);
`endif

endmodule

// File: doc/icache_line_refill.md
Name: icache_line_refill

Overview:
- Refill engine directly downstream of the instruction cache's L2 port.
- Accepts one line-address request, fetches the line as BLOCK_SIZE word reads on a 32-bit memory read channel, and assembles the words into one line buffer.
- Returns the full line with a one-cycle valid pulse, in the form the cache's DATA_FROM_L2/DATA_FROM_L2_VALID inputs expect.

Parameters:
- DATA_WIDTH, 32, memory word width in bits.
- ADDR_WIDTH, 32, byte address width.
- BLOCK_SIZE, 8, words per cache line; power of two.
- OFFSET_WIDTH (localparam), clog2(DATA_WIDTH*BLOCK_SIZE/8) = 5, line byte-offset width.
- LINE_WIDTH (localparam), BLOCK_SIZE*DATA_WIDTH = 256.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST_N  in  1  reset; asynchronous, active-low.
- FLUSH  in  1  abort the current refill.
- ADDR_FROM_L1  in  ADDR_WIDTH-OFFSET_WIDTH  line address.
- ADDR_FROM_L1_VALID  in  1  request strobe.
- DATA_TO_L1  out  LINE_WIDTH  assembled line; word i at [i*DATA_WIDTH +: DATA_WIDTH].
- DATA_TO_L1_VALID  out  1  one-cycle line-complete pulse.
- BUSY  out  1  high whenever state != IDLE.
- MEM_ADDR  out  ADDR_WIDTH  word byte address.
- MEM_RD_VALID  out  1  read request valid.
- MEM_RD_READY  in  1  read request accepted.
- MEM_RDATA  in  DATA_WIDTH  read data.
- MEM_RDATA_VALID  in  1  read data valid; responses return in order, with no backpressure.

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE, both counters=0, line buffer=0, latched address=0. All outputs are 0.
- States:
  - IDLE: request accepted when ADDR_FROM_L1_VALID=1 and FLUSH=0. Latch the address, clear issue_cnt and recv_cnt, go to FETCH.
  - FETCH: MEM_RD_VALID=(issue_cnt<BLOCK_SIZE).
    - MEM_ADDR = {line_addr, issue_cnt[clog2(BLOCK_SIZE)-1:0], clog2(DATA_WIDTH/8) zero bits}.
    - A beat is issued when MEM_RD_VALID & MEM_RD_READY; issue_cnt increments.
    - MEM_ADDR and MEM_RD_VALID hold stable while MEM_RD_VALID=1 and MEM_RD_READY=0.
    - On MEM_RDATA_VALID, write the word at slot recv_cnt; recv_cnt increments.
    - When recv_cnt reaches BLOCK_SIZE, go to DONE.
  - DONE: DATA_TO_L1_VALID=~FLUSH for exactly one cycle, then go to IDLE.
  - DRAIN: MEM_RD_VALID=0. Consume and discard responses until outstanding=0, then go to IDLE.
- Counters are clog2(BLOCK_SIZE)+1 bits wide. outstanding = issue_cnt - recv_cnt; it never exceeds BLOCK_SIZE.
- Latency, for a zero-wait memory (READY=1, data one cycle after issue):
  - Request sampled at cycle 0.
  - Beats issued at cycles 1-8.
  - Data returned at cycles 2-9.
  - DATA_TO_L1_VALID at cycle 10.
- DATA_TO_L1 stays stable from the DONE cycle until the next request is accepted.
- FLUSH in FETCH:
  - Stop issuing; any handshake pending in that cycle is not counted.
  - A response arriving in the same cycle is counted.
  - If outstanding=0 afterwards, go to IDLE; otherwise go to DRAIN.
  - No DATA_TO_L1_VALID is produced.
- FLUSH with ADDR_FROM_L1_VALID in the same IDLE cycle: FLUSH wins and the request is dropped.
- MEM_RDATA_VALID when outstanding=0 (IDLE, DONE, or spurious): ignored; the buffer is unchanged.
- ADDR_FROM_L1_VALID while BUSY: ignored, unless REFILL_PENDING_EN is defined.

Optional Feature:
- Macro: REFILL_PENDING_EN.
- Defined: adds a one-entry pending register.
  - A request arriving while BUSY (without FLUSH) is captured; a later one overwrites it.
  - On leaving DONE, a valid pending entry starts FETCH directly, skipping IDLE.
  - FLUSH clears the pending entry.
  - BUSY also covers a valid pending entry.
- Undefined: no pending register; requests while BUSY are dropped.

Decomposition:
- Package refill_pkg holds:
  - state enum {IDLE, FETCH, DONE, DRAIN};
  - default widths DATA_WIDTH/ADDR_WIDTH/BLOCK_SIZE;
  - derived OFFSET_WIDTH and LINE_WIDTH constants;
  - the word byte-shift constant.
- No sub-module. FSM, counters and line buffer stay in one module; the buffer is a plain register array.

Test Plan:
- Zero-wait memory, request 0x0000123 → MEM_ADDR 0x2460,0x2464,…,0x247C on cycles 1-8; DATA_TO_L1_VALID at cycle 10; word i equals the value returned for beat i.
- MEM_RD_READY low 3 cycles on beat 2 → MEM_ADDR held at base+8 with MEM_RD_VALID=1; line still correct; pulse delayed 3 cycles.
- Data latency 4 cycles with 4 reads outstanding → in-order assembly correct; outstanding never exceeds 8.
- FLUSH after 5 issued, 2 received → MEM_RD_VALID drops next cycle; DRAIN absorbs 3 responses; no DATA_TO_L1_VALID; IDLE afterwards; next request refills cleanly.
- RST_N asserted mid-FETCH (asynchronous) → outputs zero immediately; stray MEM_RDATA_VALID after reset is ignored.
- With REFILL_PENDING_EN, second request during FETCH → its first MEM_RD_VALID appears the cycle after the first DATA_TO_L1_VALID; without the macro, it is dropped and BUSY falls after DONE.
